answer_display_scanner: RTL and testbench

//  Consumer of the 3-bit answer-select code from the up/down/center selector FSM.

---
 rtl/answer_display_scanner.sv | 124 ++++++++++++
 tb/tb_answer_display_scanner.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/answer_display_scanner.sv
// answer_display_scanner: latches one 4-digit BCD group of the answer per frame
// and scans it onto a 4-digit common-anode seven-segment display.
module answer_display_scanner #(
    parameter int NUM_GROUPS   = 8,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [2:0]              answer_select_code,
    input  logic [16*NUM_GROUPS-1:0] answer_bcd,
    output logic [3:0]              an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [2:0]              group_latched
);

    localparam int TW = $clog2(REFRESH_DIV);
    localparam logic [TW-1:0] TICK_LAST  = TW'(REFRESH_DIV - 1);
    localparam logic [TW-1:0] TICK_BLANK = TW'(BLANK_CYCLES);

    logic [TW-1:0]           r_tick_cnt;
    logic [1:0]              r_digit_idx;
    logic                    r_load_pending;
    logic [2:0]              r_code;
    logic [16*NUM_GROUPS-1:0] r_shadow;

    logic                    w_wrap;
    logic                    w_load;
    logic                    w_blank;
    logic [15:0]             w_group;
    logic [3:0]              w_nibble;
    logic                    w_more;

    // Active-low segment pattern {g,f,e,d,c,b,a}; A is a minus sign.
    function automatic logic [6:0] f_decode(input logic [3:0] n);
        case (n)
            4'h0:    f_decode = 7'h40;
            4'h1:    f_decode = 7'h79;
            4'h2:    f_decode = 7'h24;
            4'h3:    f_decode = 7'h30;
            4'h4:    f_decode = 7'h19;
            4'h5:    f_decode = 7'h12;
            4'h6:    f_decode = 7'h02;
            4'h7:    f_decode = 7'h78;
            4'h8:    f_decode = 7'h00;
            4'h9:    f_decode = 7'h10;
            4'hA:    f_decode = 7'h3F;
            default: f_decode = 7'h7F;
        endcase
    endfunction

    assign w_wrap  = (r_tick_cnt == TICK_LAST);
    assign w_load  = r_load_pending || (w_wrap && (r_digit_idx == 2'd3));
    assign w_blank = (r_tick_cnt < TICK_BLANK);

    // Pick the latched group; an out-of-range code yields an all-blank group.
    always_comb begin
        w_group = 16'hFFFF;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            if (r_code == 3'(g)) begin
                w_group = r_shadow[16*g +: 16];
            end
        end
    end

    assign w_nibble = w_group[{r_digit_idx, 2'b00} +: 4];

    // Any visible digit (1..9 or minus) in a group left of the latched one.
    always_comb begin
        w_more = 1'b0;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            if (g > int'(r_code)) begin
                for (int n = 0; n < 4; n++) begin
                    if ((r_shadow[16*g+4*n +: 4] != 4'h0) &&
                        (r_shadow[16*g+4*n +: 4] <= 4'hA)) begin
                        w_more = 1'b1;
                    end
                end
            end
        end
    end

    // Slot timer, digit pointer and once-per-frame shadow load.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick_cnt     <= '0;
            r_digit_idx    <= 2'd0;
            r_load_pending <= 1'b1;
            r_code         <= 3'd0;
            r_shadow       <= '1;
        end else begin
            r_tick_cnt <= w_wrap ? '0 : r_tick_cnt + TW'(1);
            if (w_wrap) begin
                r_digit_idx <= r_digit_idx + 2'd1;
            end
            if (w_load) begin
                r_load_pending <= 1'b0;
                r_code         <= answer_select_code;
                r_shadow       <= answer_bcd;
            end
        end
    end

    // Registered display drive with a dark interval at the start of each slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            an  <= 4'hF;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else if (w_blank) begin
            an  <= 4'hF;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an  <= ~(4'b0001 << r_digit_idx);
            seg <= f_decode(w_nibble);
            dp  <= ~((r_digit_idx == 2'd3) && w_more);
        end
    end

    assign group_latched = r_code;

endmodule

// File: tb/tb_answer_display_scanner.sv
// tb_answer_display_scanner: directed slot-by-slot vectors for the display
// scanner with small refresh parameters.
module tb_answer_display_scanner;

    localparam int NG = 6;
    localparam int RD = 8;
    localparam int BC = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [2:0]    code;
    logic [16*NG-1:0] bcd;
    logic [3:0]    an;
    logic [6:0]    seg;
    logic          dp;
    logic [2:0]    gl;

    int checks = 0;
    int errors = 0;

    answer_display_scanner #(
        .NUM_GROUPS   (NG),
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .answer_select_code (code),
        .answer_bcd         (bcd),
        .an                 (an),
        .seg                (seg),
        .dp                 (dp),
        .group_latched      (gl)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]    code;
        logic [16*NG-1:0] bcd;
        logic [3:0]    an;
        logic [6:0]    seg;
        logic          dp;
        logic [2:0]    gl;
    } vec_t;

    vec_t vecs[32];

    function automatic vec_t mk(logic [2:0] c, logic [16*NG-1:0] b,
                                logic [3:0] a, logic [6:0] s,
                                logic d, logic [2:0] g);
        vec_t v;
        v.code = c; v.bcd = b; v.an = a; v.seg = s; v.dp = d; v.gl = g;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string nm, int idx, logic [3:0] ea, logic [6:0] es,
                       logic edp, logic [2:0] eg, bit do_gl);
        checks++;
        if ({an, seg, dp} !== {ea, es, edp}) begin
            errors++;
            $display("FAIL %s[%0d] got an=%h seg=%h dp=%b want an=%h seg=%h dp=%b",
                     nm, idx, an, seg, dp, ea, es, edp);
        end
        if (do_gl) begin
            checks++;
            if (gl !== eg) begin
                errors++;
                $display("FAIL %s[%0d] group_latched got %0d want %0d",
                         nm, idx, gl, eg);
            end
        end
    endtask

    // One digit slot: BC dark cycles then the digit; group_latched is not
    // checked on the last cycle since a frame reload may land on that edge.
    task automatic check_slot(string nm, int row, logic [3:0] ea,
                              logic [6:0] es, logic edp, logic [2:0] eg);
        for (int i = 0; i < RD; i++) begin
            step();
            if (i < BC)
                chk(nm, row*RD+i, 4'hF, 7'h7F, 1'b1, eg, i < RD-1);
            else
                chk(nm, row*RD+i, ea, es, edp, eg, i < RD-1);
        end
    endtask

    localparam logic [95:0] B0 = 96'h0000_0000_0000_0000_0000_1234;
    localparam logic [95:0] B1 = 96'h0000_0000_0000_0000_5678_1234;
    localparam logic [95:0] B3 = 96'h0000_0000_0000_0001_0000_FBA0;
    localparam logic [95:0] B4 = 96'h0000_00A0_0987_0000_0000_0000;
    localparam logic [95:0] B5 = 96'hFEDB_00A0_0000_0000_0000_0000;

    initial begin
        // Row inputs are applied before the slot; they take effect at the
        // next frame boundary (or the first cycle after reset).
        vecs[0]  = mk(3'd0, B0, 4'hE, 7'h19, 1'b1, 3'd0);
        vecs[1]  = mk(3'd0, B0, 4'hD, 7'h30, 1'b1, 3'd0);
        vecs[2]  = mk(3'd0, B0, 4'hB, 7'h24, 1'b1, 3'd0);
        vecs[3]  = mk(3'd0, B0, 4'h7, 7'h79, 1'b1, 3'd0);
        vecs[4]  = mk(3'd0, B0, 4'hE, 7'h19, 1'b1, 3'd0);
        vecs[5]  = mk(3'd1, B1, 4'hD, 7'h30, 1'b1, 3'd0);
        vecs[6]  = mk(3'd1, B1, 4'hB, 7'h24, 1'b1, 3'd0);
        vecs[7]  = mk(3'd1, B1, 4'h7, 7'h79, 1'b1, 3'd0);
        vecs[8]  = mk(3'd1, B1, 4'hE, 7'h00, 1'b1, 3'd1);
        vecs[9]  = mk(3'd1, B1, 4'hD, 7'h78, 1'b1, 3'd1);
        vecs[10] = mk(3'd1, B1, 4'hB, 7'h02, 1'b1, 3'd1);
        vecs[11] = mk(3'd7, B1, 4'h7, 7'h12, 1'b1, 3'd1);
        vecs[12] = mk(3'd7, B1, 4'hE, 7'h7F, 1'b1, 3'd7);
        vecs[13] = mk(3'd7, B1, 4'hD, 7'h7F, 1'b1, 3'd7);
        vecs[14] = mk(3'd7, B1, 4'hB, 7'h7F, 1'b1, 3'd7);
        vecs[15] = mk(3'd0, B3, 4'h7, 7'h7F, 1'b1, 3'd7);
        vecs[16] = mk(3'd0, B3, 4'hE, 7'h40, 1'b1, 3'd0);
        vecs[17] = mk(3'd0, B3, 4'hD, 7'h3F, 1'b1, 3'd0);
        vecs[18] = mk(3'd0, B3, 4'hB, 7'h7F, 1'b1, 3'd0);
        vecs[19] = mk(3'd2, B3, 4'h7, 7'h7F, 1'b0, 3'd0);
        vecs[20] = mk(3'd2, B3, 4'hE, 7'h79, 1'b1, 3'd2);
        vecs[21] = mk(3'd2, B3, 4'hD, 7'h40, 1'b1, 3'd2);
        vecs[22] = mk(3'd2, B3, 4'hB, 7'h40, 1'b1, 3'd2);
        vecs[23] = mk(3'd3, B4, 4'h7, 7'h40, 1'b1, 3'd2);
        vecs[24] = mk(3'd3, B4, 4'hE, 7'h78, 1'b1, 3'd3);
        vecs[25] = mk(3'd3, B4, 4'hD, 7'h00, 1'b1, 3'd3);
        vecs[26] = mk(3'd3, B4, 4'hB, 7'h10, 1'b1, 3'd3);
        vecs[27] = mk(3'd4, B5, 4'h7, 7'h40, 1'b0, 3'd3);
        vecs[28] = mk(3'd4, B5, 4'hE, 7'h40, 1'b1, 3'd4);
        vecs[29] = mk(3'd4, B5, 4'hD, 7'h3F, 1'b1, 3'd4);
        vecs[30] = mk(3'd4, B5, 4'hB, 7'h40, 1'b1, 3'd4);
        vecs[31] = mk(3'd4, B5, 4'h7, 7'h40, 1'b1, 3'd4);

        reset = 1'b1;
        code  = 3'd0;
        bcd   = B0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("reset", i, 4'hF, 7'h7F, 1'b1, 3'd0, 1'b1);
        end
        reset = 1'b0;

        for (int r = 0; r < 32; r++) begin
            code = vecs[r].code;
            bcd  = vecs[r].bcd;
            check_slot("vec", r, vecs[r].an, vecs[r].seg,
                       vecs[r].dp, vecs[r].gl);
        end

        // Mid-frame reset: run into slot 2 of the next frame, then reset.
        repeat (2*RD + 4) step();
        chk("pre_reset", 0, 4'hB, 7'h40, 1'b1, 3'd4, 1'b1);
        code  = 3'd0;
        bcd   = B0;
        reset = 1'b1;
        step();
        chk("mid_reset", 0, 4'hF, 7'h7F, 1'b1, 3'd0, 1'b1);
        step();
        chk("mid_reset", 1, 4'hF, 7'h7F, 1'b1, 3'd0, 1'b1);
        reset = 1'b0;
        check_slot("post_reset", 0, 4'hE, 7'h19, 1'b1, 3'd0);
        check_slot("post_reset", 1, 4'hD, 7'h30, 1'b1, 3'd0);
        check_slot("post_reset", 2, 4'hB, 7'h24, 1'b1, 3'd0);
        check_slot("post_reset", 3, 4'h7, 7'h79, 1'b1, 3'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
